// File: rtl/alarm_unit.sv
// rtl/alarm_unit.sv - alarm time store, match detection and IDLE/RING/SNOOZE buzzer state machine
// Optional hourly chime state is built when ALARM_HOURLY_CHIME_EN is defined.
module alarm_unit #(
    parameter int TICK_DIV   = 7999999,
    parameter int TONE_DIV   = 3999,
    parameter int DEB_CYC    = 79999,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       pCLK,
    input  logic       nRST,
    input  logic [3:0] HOUR_T,
    input  logic [3:0] HOUR_O,
    input  logic [3:0] MIN_T,
    input  logic [3:0] MIN_O,
    input  logic [5:0] SEC,
    input  logic       ALM_EN,
    input  logic       SET_MODE,
    input  logic       BTN_HOUR,
    input  logic       BTN_MIN,
    input  logic       BTN_SNZ,
    input  logic       BTN_STOP,
    output logic [3:0] ALM_HT,
    output logic [3:0] ALM_HO,
    output logic [3:0] ALM_MT,
    output logic [3:0] ALM_MO,
    output logic       BUZZ,
    output logic       ALM_ACTIVE,
    output logic       SNOOZED
);

    localparam int DIV_W   = $clog2(TICK_DIV + 2);
    localparam int TONE_W  = $clog2(TONE_DIV + 2);
    localparam int DEB_W   = $clog2(DEB_CYC + 2);
    localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int SEC_W   = $clog2(SEC_MAX + 2);
    localparam int SNZ_W   = $clog2(MAX_SNOOZE + 2);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'((TICK_DIV + 1) / 2);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC);
    localparam logic [SEC_W-1:0]  RING_LAST = SEC_W'(RING_SEC - 1);
    localparam logic [SEC_W-1:0]  SNZ_LAST  = SEC_W'(SNOOZE_SEC - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LIMIT = SNZ_W'(MAX_SNOOZE);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;
`ifdef ALARM_HOURLY_CHIME_EN
    localparam logic [1:0] ST_CHIME  = 2'd3;
    localparam int         CHIME_CYC = (TICK_DIV + 1) / 4;
    localparam logic [DIV_W-1:0] CHIME_LAST = DIV_W'((CHIME_CYC > 0) ? CHIME_CYC - 1 : 0);
`endif

    localparam int B_HOUR = 0;
    localparam int B_MIN  = 1;
    localparam int B_SNZ  = 2;
    localparam int B_STOP = 3;

    logic [21:0] tim_s1_q, tim_s2_q;
    logic [1:0]  lvl_s1_q, lvl_s2_q;
    logic [3:0]  btn_s1_q, btn_s2_q;
    logic        en_s, set_s;

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            tim_s1_q <= '0;
            tim_s2_q <= '0;
            lvl_s1_q <= '0;
            lvl_s2_q <= '0;
            btn_s1_q <= '1;
            btn_s2_q <= '1;
        end else begin
            tim_s1_q <= {HOUR_T, HOUR_O, MIN_T, MIN_O, SEC};
            tim_s2_q <= tim_s1_q;
            lvl_s1_q <= {ALM_EN, SET_MODE};
            lvl_s2_q <= lvl_s1_q;
            btn_s1_q <= {BTN_STOP, BTN_SNZ, BTN_MIN, BTN_HOUR};
            btn_s2_q <= btn_s1_q;
        end
    end

    assign en_s  = lvl_s2_q[1];
    assign set_s = lvl_s2_q[0];

    // Debounced level follows the synchronised button only after it has differed for DEB_CYC+1 cycles
    logic [3:0]       deb_q, deb_prev_q, press;
    logic [DEB_W-1:0] deb_cnt_q [4];

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            deb_q      <= '1;
            deb_prev_q <= '1;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                if (btn_s2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_q[i]     <= btn_s2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    assign press = deb_prev_q & ~deb_q;

    logic [3:0] alm_ht_q, alm_ho_q, alm_mt_q, alm_mo_q;
    logic [3:0] alm_ht_d, alm_ho_d, alm_mt_d, alm_mo_d;

    always_comb begin
        alm_ht_d = alm_ht_q;
        alm_ho_d = alm_ho_q;
        alm_mt_d = alm_mt_q;
        alm_mo_d = alm_mo_q;
        if (set_s && press[B_HOUR]) begin
            if (alm_ht_q == 4'd2 && alm_ho_q == 4'd3) begin
                alm_ht_d = 4'd0;
                alm_ho_d = 4'd0;
            end else if (alm_ho_q == 4'd9) begin
                alm_ht_d = alm_ht_q + 4'd1;
                alm_ho_d = 4'd0;
            end else begin
                alm_ho_d = alm_ho_q + 4'd1;
            end
        end
        if (set_s && press[B_MIN]) begin
            if (alm_mo_q == 4'd9) begin
                alm_mo_d = 4'd0;
                alm_mt_d = (alm_mt_q == 4'd5) ? 4'd0 : alm_mt_q + 4'd1;
            end else begin
                alm_mo_d = alm_mo_q + 4'd1;
            end
        end
    end

    logic match, match_q, match_rise;
    assign match      = (tim_s2_q[21:6] == {alm_ht_q, alm_ho_q, alm_mt_q, alm_mo_q}) &&
                        (tim_s2_q[5:0] == 6'd0);
    assign match_rise = match & ~match_q;

`ifdef ALARM_HOURLY_CHIME_EN
    logic hour_hit, hour_q;
    assign hour_hit = (tim_s2_q[13:6] == 8'd0) && (tim_s2_q[5:0] == 6'd0);
`endif

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SEC_W-1:0]  tsec_q, tsec_d;
    logic [SNZ_W-1:0]  snz_q, snz_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tone_q, tone_d;
    logic              buzz_q, buzz_d, active_q, snoozed_q;
    logic              tick, abort;

    assign tick  = (div_q == DIV_LAST);
    assign abort = press[B_STOP] | ~en_s | set_s;

    always_comb begin
        state_d = state_q;
        snz_d   = snz_q;
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        tsec_d  = tsec_q + SEC_W'(tick);
        case (state_q)
            ST_IDLE: begin
                if (match_rise && en_s && !set_s) begin
                    state_d = ST_RING;
                    snz_d   = '0;
                end
`ifdef ALARM_HOURLY_CHIME_EN
                else if (hour_hit && !hour_q && en_s && !set_s && !match) begin
                    state_d = ST_CHIME;
                end
`endif
            end
            ST_RING: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick && tsec_q == RING_LAST) begin
                    state_d = ST_IDLE;
                end else if (press[B_SNZ] && snz_q < SNZ_LIMIT) begin
                    state_d = ST_SNOOZE;
                    snz_d   = snz_q + SNZ_W'(1);
                end
            end
            ST_SNOOZE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick && tsec_q == SNZ_LAST) begin
                    state_d = ST_RING;
                end
            end
`ifdef ALARM_HOURLY_CHIME_EN
            ST_CHIME: begin
                if (!en_s || set_s) begin
                    state_d = ST_IDLE;
                end else if (match) begin
                    state_d = ST_RING;
                    snz_d   = '0;
                end else if (div_q == CHIME_LAST) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Every state change restarts the second divider and the per-state second count
        if (state_d != state_q) begin
            div_d  = '0;
            tsec_d = '0;
        end

        // Tone phase realigns to the start of every second
        if (div_d == '0) begin
            tone_cnt_d = '0;
            tone_d     = 1'b1;
        end else if (tone_cnt_q == TONE_LAST) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
        end else begin
            tone_cnt_d = tone_cnt_q + TONE_W'(1);
            tone_d     = tone_q;
        end

        buzz_d = tone_d && (state_d == ST_RING) && (div_d < DIV_HALF);
`ifdef ALARM_HOURLY_CHIME_EN
        if (state_d == ST_CHIME) buzz_d = tone_d;
`endif
    end

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            alm_ht_q   <= 4'd0;
            alm_ho_q   <= 4'd7;
            alm_mt_q   <= 4'd0;
            alm_mo_q   <= 4'd0;
            match_q    <= 1'b0;
            state_q    <= ST_IDLE;
            div_q      <= '0;
            tsec_q     <= '0;
            snz_q      <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            buzz_q     <= 1'b0;
            active_q   <= 1'b0;
            snoozed_q  <= 1'b0;
        end else begin
            alm_ht_q   <= alm_ht_d;
            alm_ho_q   <= alm_ho_d;
            alm_mt_q   <= alm_mt_d;
            alm_mo_q   <= alm_mo_d;
            match_q    <= match;
            state_q    <= state_d;
            div_q      <= div_d;
            tsec_q     <= tsec_d;
            snz_q      <= snz_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            buzz_q     <= buzz_d;
            active_q   <= (state_d == ST_RING);
            snoozed_q  <= (state_d == ST_SNOOZE);
        end
    end

`ifdef ALARM_HOURLY_CHIME_EN
    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) hour_q <= 1'b0;
        else       hour_q <= hour_hit;
    end
`endif

    assign ALM_HT     = alm_ht_q;
    assign ALM_HO     = alm_ho_q;
    assign ALM_MT     = alm_mt_q;
    assign ALM_MO     = alm_mo_q;
    assign BUZZ       = buzz_q;
    assign ALM_ACTIVE = active_q;
    assign SNOOZED    = snoozed_q;

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
- Alarm stage placed directly downstream of the digital clock counter.
- Consumes the clock's BCD hour/minute digits and its seconds count, holds a user-settable alarm time, and drives a piezo buzzer through an IDLE/RING/SNOOZE state machine.
- Alarm digits are exported so the display mux can show them while the alarm is being set.
- Single clock domain on pCLK; all asynchronous inputs are synchronised internally.

Parameters:
TICK_DIV, 7999999, pCLK cycles per internal second minus 1 (8 MHz board)
TONE_DIV, 3999, pCLK cycles per buzzer half-period minus 1 (1 kHz tone)
DEB_CYC, 79999, debounce stability window minus 1 (10 ms)
RING_SEC, 60, ring duration in seconds before auto-stop
SNOOZE_SEC, 300, snooze interval in seconds
MAX_SNOOZE, 3, snoozes allowed per alarm event

Ports:
pCLK  in  1  system clock
nRST  in  1  reset, asynchronous, active-low
HOUR_T  in  4  clock hour tens, BCD
HOUR_O  in  4  clock hour ones, BCD
MIN_T  in  4  clock minute tens, BCD
MIN_O  in  4  clock minute ones, BCD
SEC  in  6  clock seconds, 0..59
ALM_EN  in  1  alarm armed, active-high level (slide switch)
SET_MODE  in  1  1 = alarm-set mode, level
BTN_HOUR  in  1  push button, active-low
BTN_MIN  in  1  push button, active-low
BTN_SNZ  in  1  push button, active-low
BTN_STOP  in  1  push button, active-low
ALM_HT/ALM_HO/ALM_MT/ALM_MO  out  4 each  alarm time digits, BCD
BUZZ  out  1  buzzer drive
ALM_ACTIVE  out  1  1 while state is RING
SNOOZED  out  1  1 while state is SNOOZE

Behaviour:
- Reset values:
  - Alarm time 07:00: ALM_HT=0, ALM_HO=7, ALM_MT=0, ALM_MO=0.
  - BUZZ=0, ALM_ACTIVE=0, SNOOZED=0.
  - State IDLE; all counters 0; snooze count 0.
- Input synchronisation:
  - All inputs pass a 2-flop synchroniser.
  - Buttons then debounce: the debounced level updates only after the synchronised level is stable for DEB_CYC+1 cycles.
  - A press is a 1-cycle pulse on a debounced 1->0 transition.
  - Release and bounce produce no pulse.
- Alarm set, SET_MODE=1 only:
  - HOUR press: alarm hour 00->01->...->23->00, BCD.
  - MIN press: alarm minute 00..59->00, BCD, no carry into the hour.
  - Presses are ignored while SET_MODE=0.
- Match detection:
  - match = synchronised digits equal the alarm digits AND SEC==0.
  - Only the rising edge of match triggers.
  - In 12h clock mode the hours run 00..11, so alarm hours 12..23 never match.
- Tick:
  - Internal divider counts 0..TICK_DIV and produces a 1-cycle tick at TICK_DIV.
  - The divider restarts at 0 on every entry into RING or SNOOZE.
- IDLE:
  - Match rising edge with ALM_EN=1 and SET_MODE=0 -> RING, snooze count cleared.
  - ALM_ACTIVE rises on the 3rd pCLK edge after the edge at which matching inputs are first presented.
- RING:
  - BUZZ toggles every TONE_DIV+1 cycles while the divider < (TICK_DIV+1)/2; otherwise BUZZ=0 (0.5 s on/off cadence).
  - Exits:
    - BTN_STOP press -> IDLE.
    - BTN_SNZ press with snooze count < MAX_SNOOZE -> SNOOZE, count+1.
    - BTN_SNZ press at the limit is ignored.
    - RING_SEC ticks elapsed -> IDLE.
    - ALM_EN=0 or SET_MODE=1 -> IDLE.
- SNOOZE:
  - BUZZ=0.
  - After SNOOZE_SEC ticks -> RING, with the ring timer restarted.
  - BTN_STOP, ALM_EN=0 or SET_MODE=1 -> IDLE.
- Simultaneous events:
  - Priority: STOP/ALM_EN/SET_MODE > timeout > SNZ.
  - Match edges are ignored outside IDLE.
- Output timing:
  - BUZZ is forced to 0 in the same cycle the state leaves RING.
  - All outputs are registered.
- Reset mid-ring or mid-snooze returns to IDLE with silence on the next cycle and restores the alarm time to 07:00.

Optional Feature:
- ALARM_HOURLY_CHIME_EN defined:
  - Extra CHIME state, entered from IDLE when the synchronised MIN_T=MIN_O=0 and SEC==0 (rising edge), with ALM_EN=1, SET_MODE=0 and no alarm match.
  - BUZZ emits tone for (TICK_DIV+1)/4 cycles, then -> IDLE.
  - Any alarm match during CHIME -> RING.
  - ALM_ACTIVE stays 0 in CHIME.
- Undefined: no CHIME state; BUZZ stays 0 outside RING.

Test Plan:
All scenarios use bench parameters TICK_DIV=9, TONE_DIV=1, DEB_CYC=3, RING_SEC=4, SNOOZE_SEC=2, MAX_SNOOZE=1.
- Set and wrap: SET_MODE=1, 17 HOUR presses -> ALM_HT=0, ALM_HO=0 (07+17 wraps to 00). Then 61 MIN presses -> ALM_MT=0, ALM_MO=1.
- Bounce rejection: BTN_MIN low for 2 cycles three times, then held 4+ cycles -> exactly one minute increment.
- Trigger: alarm 07:00, ALM_EN=1, inputs 06:59:59 -> 07:00:00 -> ALM_ACTIVE=1 on the 3rd edge. BUZZ toggles every 2 cycles during the first 5 cycles of each 10-cycle tick. IDLE after 40 cycles.
- Snooze: in RING press SNZ -> SNOOZED=1, BUZZ=0 for 20 cycles, then RING. Second SNZ press ignored. STOP -> IDLE, BUZZ=0 the same cycle.
- Guards: match with ALM_EN=0 -> stays IDLE. SNZ and STOP pressed the same cycle -> IDLE. nRST low mid-ring -> all outputs at reset values immediately.
